uart_rx_os: RTL and testbench

Parametrised UART receiver, successor to the fixed 16x-oversampled 8-bit receiver. Samples an asynchronous serial line at OVERSAMPLE clocks per bit with majority voting, supports selectable width, parity mode and stop-bit count, and delivers bytes over a valid/ready handshake. It sits between the board RX pin and the command-parsing logic; errors are reported as single-cycle pulses.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_fifo.sv | 54 +++++
 rtl/uart_rx_os.sv | 234 +++++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } rx_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO with first-word-fall-through output; head reads 0 when empty.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with 2-of-3 majority voting and valid/ready output.
// UART_RX_FIFO_EN selects a FIFO_DEPTH-entry FIFO instead of a single holding register.
//
// state     | meaning
// WAIT_IDLE | line must stay high OVERSAMPLE cycles before frames are accepted
// IDLE      | waiting for a falling edge
// START     | validating the start bit
// DATA      | shifting in data bits, LSB first
// PAR       | checking the parity bit
// STOP      | checking stop bits
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 1,
    parameter int STOP_BITS  = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             rx_clk,
    input  logic             rx_rst_n,
    input  logic             rx_data,
    output logic [WIDTH-1:0] rx_data_out,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CW = clog2(OVERSAMPLE);
    localparam int BW = clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] SAMP_A   = CW'(OVERSAMPLE / 2 - 2);
    localparam logic [CW-1:0] SAMP_B   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] SAMP_C   = CW'(OVERSAMPLE / 2);
    localparam logic [BW-1:0] DATA_LAST = BW'(WIDTH - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    rx_state_e        state_q, state_d;
    logic             sync1_q, sync2_q, line_prev_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [1:0]       samp_q, samp_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             par_bad_q, par_bad_d;
    logic             done_q, done_d;
    logic             ferr_q, ferr_d;
    logic             parity_err_q, frame_err_q, overrun_q;
    logic             maj;
    logic             exp_par;
    logic             good_frame;

    assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & sync2_q) | (samp_q[1] & sync2_q);
    assign exp_par = (PARITY == PAR_ODD) ? ~(^data_q) : ^data_q;

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            line_prev_q <= 1'b1;
        end else begin
            sync1_q     <= rx_data;
            sync2_q     <= sync1_q;
            line_prev_q <= sync2_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        bit_cnt_d = bit_cnt_q;
        samp_d    = samp_q;
        data_d    = data_q;
        par_bad_d = par_bad_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;
        if (cnt_q == SAMP_A) samp_d[0] = sync2_q;
        if (cnt_q == SAMP_B) samp_d[1] = sync2_q;
        case (state_q)
            WAIT_IDLE: begin
                if (!sync2_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            IDLE: begin
                cnt_d = '0;
                if (line_prev_q && !sync2_q) begin
                    state_d   = START;
                    bit_cnt_d = '0;
                    par_bad_d = 1'b0;
                end
            end
            START: begin
                if (cnt_q == SAMP_C) state_d = maj ? IDLE : DATA;
            end
            DATA: begin
                if (cnt_q == SAMP_C) begin
                    data_d = {maj, data_q[WIDTH-1:1]};
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != PAR_NONE) ? PAR : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            PAR: begin
                if (cnt_q == SAMP_C) begin
                    par_bad_d = (maj != exp_par);
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (cnt_q == SAMP_C) begin
                    // A low stop bit (including a break) discards the frame and
                    // waits for a clean idle line before hunting for a start.
                    if (!maj) begin
                        ferr_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = WAIT_IDLE;
                    end else if (bit_cnt_q == STOP_LAST) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            state_q      <= WAIT_IDLE;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            samp_q       <= '0;
            data_q       <= '0;
            par_bad_q    <= 1'b0;
            done_q       <= 1'b0;
            ferr_q       <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            samp_q       <= samp_d;
            data_q       <= data_d;
            par_bad_q    <= par_bad_d;
            done_q       <= done_d;
            ferr_q       <= ferr_d;
            parity_err_q <= done_q & par_bad_q;
            frame_err_q  <= ferr_q;
        end
    end

    assign good_frame = done_q & ~par_bad_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

`ifdef UART_RX_FIFO_EN
    logic fifo_full, fifo_empty, fifo_pop, push_q;

    assign fifo_pop = rx_valid & rx_ready;
    assign rx_valid = ~fifo_empty;

    // The room check is made one cycle ahead of the push; nothing else can
    // fill the FIFO in between, so the decision still holds at the write.
    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            push_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            push_q    <= good_frame & ~(fifo_full & ~fifo_pop);
            overrun_q <= good_frame & fifo_full & ~fifo_pop;
        end
    end

    uart_rx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (rx_clk),
        .rst_n     (rx_rst_n),
        .push      (push_q),
        .push_data (data_q),
        .pop       (fifo_pop),
        .pop_data  (rx_data_out),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );
`else
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             valid_q, valid_d;
    logic             overrun_d;

    always_comb begin
        hold_d    = hold_q;
        valid_d   = valid_q & ~rx_ready;
        overrun_d = 1'b0;
        if (good_frame) begin
            if (valid_q && !rx_ready) begin
                overrun_d = 1'b1;
            end else begin
                hold_d  = data_q;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            hold_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign rx_data_out = hold_q;
    assign rx_valid    = valid_q;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: 8 data bits, even parity, 2 stop bits, 16x oversampling.
module tb_uart_rx_os;

    logic       rx_clk;
    logic       rx_rst_n;
    logic       rx_data;
    logic [7:0] rx_data_out;
    logic       rx_valid;
    logic       rx_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t0 = 0;
    int rise_cyc = -1;
    int n_rise = 0;
    int n_par = 0;
    int n_frm = 0;
    int n_ovr = 0;
    logic valid_prev = 1'b0;
    logic [7:0] got[$];

`ifdef UART_RX_FIFO_EN
    localparam int LAT = 189;
`else
    localparam int LAT = 188;
`endif

    uart_rx_os #(
        .WIDTH      (8),
        .OVERSAMPLE (16),
        .PARITY     (1),
        .STOP_BITS  (2),
        .FIFO_DEPTH (4)
    ) dut (
        .rx_clk      (rx_clk),
        .rx_rst_n    (rx_rst_n),
        .rx_data     (rx_data),
        .rx_data_out (rx_data_out),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    initial rx_clk = 1'b0;
    always #5 rx_clk = ~rx_clk;

    always @(posedge rx_clk) cyc++;

    // Observes one cycle's settled inputs/outputs ahead of the next rising edge.
    always @(negedge rx_clk) begin
        #1;
        if (rx_valid && rx_ready) got.push_back(rx_data_out);
        if (rx_valid && !valid_prev) begin
            rise_cyc = cyc;
            n_rise++;
        end
        valid_prev = rx_valid;
        if (parity_err) n_par++;
        if (frame_err)  n_frm++;
        if (overrun)    n_ovr++;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic idle(input int n);
        rx_data = 1'b1;
        repeat (n) @(negedge rx_clk);
    endtask

    // bit 0 = start, 1..8 data, 9 parity, 10..11 stop; brk keeps the line low from the first stop bit.
    task automatic send_frame(input logic [7:0] d, input bit flip_par, input bit brk, input int abort_at);
        logic [11:0] bits;
        bits = {~brk, ~brk, (^d) ^ flip_par, d, 1'b0};
        @(negedge rx_clk);
        t0 = cyc + 1;
        for (int i = 0; i < 12; i++) begin
            rx_data = bits[i];
            if (i == abort_at) begin
                repeat (8) @(negedge rx_clk);
                rx_rst_n = 1'b0;
                rx_data  = 1'b1;
                return;
            end
            repeat (16) @(negedge rx_clk);
        end
        if (!brk) rx_data = 1'b1;
    endtask

    initial begin
        logic [7:0] vec [5];
        vec[0] = 8'h34; vec[1] = 8'hA8; vec[2] = 8'hB4; vec[3] = 8'h5C; vec[4] = 8'h0F;
        rx_rst_n = 1'b0;
        rx_data  = 1'b1;
        rx_ready = 1'b1;
        repeat (3) @(negedge rx_clk);
        check_val("rst_valid", rx_valid, 0);
        check_val("rst_data", rx_data_out, 0);
        check_val("rst_perr", parity_err, 0);
        check_val("rst_ferr", frame_err, 0);
        check_val("rst_ovr", overrun, 0);
        rx_rst_n = 1'b1;
        idle(24);

        for (int i = 0; i < 3; i++) begin
            send_frame(vec[i], 1'b0, 1'b0, -1);
            idle(32);
            check_val("good_latency", rise_cyc - t0, LAT);
        end
        check_val("good_count", got.size(), 3);
        for (int i = 0; i < 3; i++) check_val("good_data", got[i], vec[i]);
        check_val("good_no_errs", n_par + n_frm + n_ovr, 0);

        send_frame(8'h34, 1'b1, 1'b0, -1);
        idle(32);
        check_val("par_pulse", n_par, 1);
        check_val("par_no_data", got.size(), 3);
        send_frame(8'hA8, 1'b0, 1'b0, -1);
        idle(32);
        check_val("after_par_count", got.size(), 4);
        check_val("after_par_data", got[3], 8'hA8);

        send_frame(8'hB4, 1'b0, 1'b1, -1);
        repeat (30 * 16) @(negedge rx_clk);
        idle(32);
        check_val("brk_ferr", n_frm, 1);
        check_val("brk_no_perr", n_par, 1);
        check_val("brk_no_data", got.size(), 4);
        send_frame(8'h34, 1'b0, 1'b0, -1);
        idle(32);
        check_val("after_brk_count", got.size(), 5);
        check_val("after_brk_data", got[4], 8'h34);
        check_val("after_brk_ferr", n_frm, 1);

        begin
            int rises;
            rises = n_rise;
            @(negedge rx_clk);
            rx_data = 1'b0;
            repeat (5) @(negedge rx_clk);
            idle(40);
            check_val("glitch_no_valid", n_rise, rises);
            check_val("glitch_no_flags", n_par * 100 + n_frm * 10 + n_ovr, 110);
            check_val("glitch_no_data", got.size(), 5);
        end

        rx_ready = 1'b0;
`ifdef UART_RX_FIFO_EN
        for (int i = 0; i < 4; i++) begin
            send_frame(vec[i], 1'b0, 1'b0, -1);
            idle(32);
        end
        check_val("fifo_no_ovr", n_ovr, 0);
        check_val("fifo_head", rx_data_out, 8'h34);
        send_frame(vec[4], 1'b0, 1'b0, -1);
        idle(32);
        check_val("fifo_ovr", n_ovr, 1);
        rx_ready = 1'b1;
        idle(10);
        rx_ready = 1'b0;
        check_val("fifo_drain_count", got.size(), 9);
        for (int i = 0; i < 4; i++) check_val("fifo_drain_data", got[5 + i], vec[i]);
        check_val("fifo_empty", rx_valid, 0);
`else
        send_frame(8'h34, 1'b0, 1'b0, -1);
        idle(32);
        check_val("hold_valid", rx_valid, 1);
        check_val("hold_data", rx_data_out, 8'h34);
        check_val("hold_no_ovr", n_ovr, 0);
        send_frame(8'hA8, 1'b0, 1'b0, -1);
        idle(32);
        check_val("hold_ovr", n_ovr, 1);
        check_val("hold_kept", rx_data_out, 8'h34);
        rx_ready = 1'b1;
        idle(4);
        rx_ready = 1'b0;
        check_val("hold_drain_count", got.size(), 6);
        check_val("hold_drain_data", got[5], 8'h34);
        check_val("hold_empty", rx_valid, 0);
`endif

        begin
            int base;
            int ovr0;
            rx_ready = 1'b1;
            base = got.size();
            ovr0 = n_ovr;
            send_frame(8'hA8, 1'b0, 1'b0, 4);
            #1;
            check_val("midrst_valid", rx_valid, 0);
            check_val("midrst_data", rx_data_out, 0);
            check_val("midrst_flags", {29'd0, parity_err, frame_err, overrun}, 0);
            repeat (3) @(negedge rx_clk);
            rx_rst_n = 1'b1;
            idle(20);
            send_frame(8'hA8, 1'b0, 1'b0, -1);
            idle(32);
            check_val("midrst_count", got.size(), base + 1);
            check_val("midrst_rx", got[got.size() - 1], 8'hA8);
            check_val("midrst_no_flags", n_par * 100 + n_frm * 10 + n_ovr, 110 + ovr0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
